mmio_bus: RTL
=============

# mmio_bus

Parametrised memory-mapped bus that replaces the fixed IROM/DRAM/device decode of the CPU memory subsystem. It serves an instruction-fetch port and a data port and arbitrates both onto a shared single-port IROM. It routes data accesses to DRAM or to a configurable bank of device registers: outputs such as seg7 digits and enables, inputs such as buttons, and sticky edge-capture registers. All read responses are tagged with a one-cycle-latency valid, so the core no longer infers read source from delayed write strobes.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, data width; a multiple of 8
- IROM_BYTES, 4096, IROM occupies [0, IROM_BYTES)
- DRAM_BYTES, 4096, DRAM occupies [IROM_BYTES, IROM_BYTES+DRAM_BYTES)
- DEV_BASE, 8192, base byte address of the device window
- N_OUT, 2, number of writable output registers
- N_IN, 1, number of input channels

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_stall_o  out  1  fetch refused this cycle (combinational)
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_WIDTH  fetch data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  write data
- d_wstrb_i  in  DATA_WIDTH/8  byte strobes
- d_rvalid_o  out  1  read data valid (reads only)
- d_rdata_o  out  DATA_WIDTH  read data
- irom_addr_o  out  ADDR_WIDTH  IROM address
- irom_rdata_i  in  DATA_WIDTH  IROM data, one-cycle latency
- dram_we_o  out  DATA_WIDTH/8  DRAM byte write enables
- dram_addr_o  out  ADDR_WIDTH  DRAM address
- dram_wdata_o  out  DATA_WIDTH  DRAM write data
- dram_rdata_i  in  DATA_WIDTH  DRAM data, one-cycle latency
- dev_out_o  out  N_OUT*DATA_WIDTH  output registers, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
- dev_in_i  in  N_IN*DATA_WIDTH  asynchronous device inputs
- err_o  out  1  bus-error pulse (MMIO_BUS_ERR_EN only)

## Operation
- Decode on d_addr_i: IROM, DRAM, device window, otherwise unmapped.
- Device window word index w = (d_addr_i-DEV_BASE)>>2:
  - w < N_OUT: output register k = w; read/write.
  - N_OUT ≤ w < N_OUT+N_IN: input channel, 2-flop synchronised; read-only.
  - N_OUT+N_IN ≤ w < N_OUT+2*N_IN: sticky capture for that channel; read-only; a read clears it.
  - Any higher w: unmapped.
- Output register writes honour d_wstrb_i per byte.
- Sticky capture: each cycle, cap ← (cap & ~clr) | (sync & ~sync_prev). clr equals cap on a read of that slot, else 0. An edge arriving in the same cycle as the read is retained.
- IROM is read-only. A data write to IROM or to unmapped space is dropped.
- Unmapped reads return 0 with d_rvalid_o=1.
- Arbitration: a data request to IROM wins over a fetch.
  - if_stall_o = if_req_i & d_req_i & (d_addr_i in IROM).
  - irom_addr_o = d_addr_i when the data request wins, else if_addr_i.
- DRAM ports are combinational from the data port. dram_we_o = d_wstrb_i when d_req_i & d_we_i & DRAM hit, else 0.
- Response source (IROM/DRAM/device/zero) is registered with the request and selects d_rdata_o in the response cycle.

## Timing
- An accepted read in cycle t gives d_rvalid_o=1 with data in t+1. The same holds for fetch with if_rvalid_o.
- Back-to-back requests every cycle are supported; no bubbles.
- Writes complete in the request cycle: device registers update at the edge ending t, and a read in t+1 returns the new value.
- A stalled fetch gets if_rvalid_o=0 in t+1; the core re-presents it.
- Reset values: if_rvalid_o, d_rvalid_o, err_o, dev_out_o, captures and synchronisers are 0. if_rdata_o and d_rdata_o are 0 when the corresponding valid is 0.
- Reset asserted mid-transaction: the pending valid is dropped in the following cycle and no response is issued.

## Configuration
- MMIO_BUS_ERR_EN defined:
  - err_o pulses 1 in cycle t+1 for a write to IROM, or any access to unmapped space.
  - The offending address is latched in an internal register at device word index N_OUT+2*N_IN, which is readable and cleared on read.
- MMIO_BUS_ERR_EN undefined: err_o is tied 0, the register does not exist, and that index reads 0.

## Structure
- Package mmio_bus_pkg holds:
  - the region enum (REG_IROM, REG_DRAM, REG_DEV, REG_NONE)
  - the word-offset helper constants
  - default address-map localparams
- Sub-module mmio_dev_in: one input channel with 2-flop sync, edge detect and sticky capture. Instantiated N_IN times via generate.

## Test plan
- Reset, then read DEV_BASE+0 → d_rvalid_o=1 at t+1 with data 0. dev_out_o=0 and err_o=0 throughout.
- Write 0x1234 with wstrb=4'b0011 to DEV_BASE+0, then read the same address → 0x00001234 at t+2. A second write of 0xAB00_0000 with wstrb=4'b1000 → read gives 0xAB001234.
- Fetch 0x0010 and data read 0x0020 in the same cycle → if_stall_o=1 and irom_addr_o=0x0020. d_rvalid_o=1 next cycle, if_rvalid_o=0. The re-presented fetch returns in the following cycle.
- Write to 0x1000 with wstrb=4'hF → dram_we_o=4'hF in that cycle. A write to 0x0008 → dram_we_o=0 and no IROM write; with MMIO_BUS_ERR_EN, err_o=1 at t+1.
- Drive a 0→1 edge on dev_in_i bit 2 (N_OUT=2, N_IN=1) and wait 3 cycles. Read the capture at DEV_BASE+12 → 0x4; an immediate re-read → 0. A new edge landing in the read cycle is still present on the next read.
- Read DEV_BASE+0x100 → data 0 with valid. Assert rst in the cycle after a DRAM read request → d_rvalid_o=0.

Source files
------------

// File: rtl/mmio_bus_pkg.sv
// Shared types and address-map defaults for the memory-mapped bus.
package mmio_bus_pkg;

  typedef enum logic [1:0] {REG_IROM, REG_DRAM, REG_DEV, REG_NONE} region_e;

  // Device registers are word-spaced; byte offset >> WORD_SHIFT gives the slot.
  localparam int WORD_SHIFT = 2;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_IROM_BYTES = 4096;
  localparam int DEF_DRAM_BYTES = 4096;
  localparam int DEF_DEV_BASE   = 8192;
  localparam int DEF_N_OUT      = 2;
  localparam int DEF_N_IN       = 1;

  function automatic region_e decode(input logic [31:0] a, input int irom_bytes,
                                     input int dram_bytes, input int dev_base);
    if (a < 32'(irom_bytes))              return REG_IROM;
    if (a < 32'(irom_bytes + dram_bytes)) return REG_DRAM;
    if (a >= 32'(dev_base))               return REG_DEV;
    return REG_NONE;
  endfunction

  function automatic logic [31:0] dev_word(input logic [31:0] a, input int dev_base);
    return (a - 32'(dev_base)) >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/mmio_dev_in.sv
// One device input channel: 2-flop synchroniser, rising-edge detect, sticky capture.
module mmio_dev_in #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] clr_i,
  output logic [DATA_WIDTH-1:0] sync_o,
  output logic [DATA_WIDTH-1:0] cap_o
);

  logic [DATA_WIDTH-1:0] meta_q, sync_q, prev_q, cap_q, cap_d;

  // An edge seen in the same cycle as a clearing read survives the clear.
  assign cap_d = (cap_q & ~clr_i) | (sync_q & ~prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      cap_q  <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      cap_q  <= cap_d;
    end
  end

  assign sync_o = sync_q;
  assign cap_o  = cap_q;

endmodule

// File: rtl/mmio_bus.sv
// Fetch/data bus onto shared IROM, DRAM and a device register bank.
// Define MMIO_BUS_ERR_EN for the bus-error pulse and latched error-address register.
module mmio_bus
  import mmio_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IROM_BYTES = DEF_IROM_BYTES,
  parameter int DRAM_BYTES = DEF_DRAM_BYTES,
  parameter int DEV_BASE   = DEF_DEV_BASE,
  parameter int N_OUT      = DEF_N_OUT,
  parameter int N_IN       = DEF_N_IN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           if_req_i,
  input  logic [ADDR_WIDTH-1:0]          if_addr_i,
  output logic                           if_stall_o,
  output logic                           if_rvalid_o,
  output logic [DATA_WIDTH-1:0]          if_rdata_o,
  input  logic                           d_req_i,
  input  logic                           d_we_i,
  input  logic [ADDR_WIDTH-1:0]          d_addr_i,
  input  logic [DATA_WIDTH-1:0]          d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        d_wstrb_i,
  output logic                           d_rvalid_o,
  output logic [DATA_WIDTH-1:0]          d_rdata_o,
  output logic [ADDR_WIDTH-1:0]          irom_addr_o,
  input  logic [DATA_WIDTH-1:0]          irom_rdata_i,
  output logic [DATA_WIDTH/8-1:0]        dram_we_o,
  output logic [ADDR_WIDTH-1:0]          dram_addr_o,
  output logic [DATA_WIDTH-1:0]          dram_wdata_o,
  input  logic [DATA_WIDTH-1:0]          dram_rdata_i,
  output logic [N_OUT*DATA_WIDTH-1:0]    dev_out_o,
  input  logic [N_IN*DATA_WIDTH-1:0]     dev_in_i,
  output logic                           err_o
);

  localparam int SW      = DATA_WIDTH / 8;
  localparam int IDX_IN  = N_OUT;
  localparam int IDX_CAP = N_OUT + N_IN;
  localparam int IDX_ERR = N_OUT + 2 * N_IN;
`ifdef MMIO_BUS_ERR_EN
  localparam int N_SLOTS = IDX_ERR + 1;
`else
  localparam int N_SLOTS = IDX_ERR;
`endif

  // ---------------- decode ----------------
  logic [31:0] d_a, w;
  region_e     d_reg, src_d, src_q;
  logic        d_rd, d_wr, d_irom, dev_hit, unmapped;

  assign d_a      = 32'(d_addr_i);
  assign d_reg    = decode(d_a, IROM_BYTES, DRAM_BYTES, DEV_BASE);
  assign w        = dev_word(d_a, DEV_BASE);
  assign d_rd     = d_req_i & ~d_we_i;
  assign d_wr     = d_req_i & d_we_i;
  assign dev_hit  = (d_reg == REG_DEV) && (w < 32'(N_SLOTS));
  assign unmapped = (d_reg == REG_NONE) || ((d_reg == REG_DEV) && !dev_hit);
  assign src_d    = unmapped ? REG_NONE : d_reg;

  // ---------------- IROM arbitration and DRAM ----------------
  assign d_irom       = d_req_i && (d_reg == REG_IROM);
  assign if_stall_o   = if_req_i & d_irom;
  assign irom_addr_o  = d_irom ? d_addr_i : if_addr_i;

  assign dram_addr_o  = d_addr_i;
  assign dram_wdata_o = d_wdata_i;
  assign dram_we_o    = (d_wr && (d_reg == REG_DRAM)) ? d_wstrb_i : '0;

  // ---------------- device inputs ----------------
  logic [N_IN-1:0][DATA_WIDTH-1:0] din, sync, cap, clr;
  assign din = dev_in_i;

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    assign clr[j] = (d_rd && dev_hit && (w == 32'(IDX_CAP + j))) ? cap[j] : '0;
    mmio_dev_in #(.DATA_WIDTH(DATA_WIDTH)) u_in (
      .clk    (clk),
      .rst    (rst),
      .in_i   (din[j]),
      .clr_i  (clr[j]),
      .sync_o (sync[j]),
      .cap_o  (cap[j])
    );
  end

  // ---------------- output registers ----------------
  logic [N_OUT-1:0][DATA_WIDTH-1:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (d_wr && dev_hit && (w == 32'(k))) begin
        for (int b = 0; b < SW; b++)
          if (d_wstrb_i[b]) out_d[k][b*8 +: 8] = d_wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign dev_out_o = out_q;

  // ---------------- error reporting ----------------
`ifdef MMIO_BUS_ERR_EN
  logic                  err_q, bad, err_clr;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  assign bad     = d_req_i && (unmapped || (d_we_i && (d_reg == REG_IROM)));
  assign err_clr = d_rd && dev_hit && (w == 32'(IDX_ERR));

  // A fresh error takes priority over a clearing read of the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= bad;
      if (bad)          err_addr_q <= d_addr_i;
      else if (err_clr) err_addr_q <= '0;
    end
  end

  assign err_o = err_q & ~rst;
`else
  assign err_o = 1'b0;
`endif

  // ---------------- device read mux ----------------
  logic [DATA_WIDTH-1:0] dev_rdata, dev_rdata_q;

  always_comb begin
    dev_rdata = '0;
    for (int k = 0; k < N_OUT; k++)
      if (w == 32'(k)) dev_rdata = out_q[k];
    for (int j = 0; j < N_IN; j++) begin
      if (w == 32'(IDX_IN + j))  dev_rdata = sync[j];
      if (w == 32'(IDX_CAP + j)) dev_rdata = cap[j];
    end
`ifdef MMIO_BUS_ERR_EN
    if (w == 32'(IDX_ERR)) dev_rdata = DATA_WIDTH'(err_addr_q);
`endif
  end

  // ---------------- response stage ----------------
  logic d_rvalid_q, if_rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_rvalid_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      src_q       <= REG_NONE;
      dev_rdata_q <= '0;
    end else begin
      d_rvalid_q  <= d_rd;
      if_rvalid_q <= if_req_i & ~if_stall_o;
      if (d_rd) begin
        src_q       <= src_d;
        dev_rdata_q <= dev_rdata;
      end
    end
  end

  // Reset kills an in-flight response in the very cycle it is asserted.
  assign d_rvalid_o  = d_rvalid_q & ~rst;
  assign if_rvalid_o = if_rvalid_q & ~rst;
  assign if_rdata_o  = if_rvalid_o ? irom_rdata_i : '0;

  always_comb begin
    d_rdata_o = '0;
    if (d_rvalid_o) begin
      case (src_q)
        REG_IROM: d_rdata_o = irom_rdata_i;
        REG_DRAM: d_rdata_o = dram_rdata_i;
        REG_DEV:  d_rdata_o = dev_rdata_q;
        default:  d_rdata_o = '0;
      endcase
    end
  end

endmodule
